// File: rtl/alu_mult_seq_if.sv
// Start/busy/done handshake and operand/result bus for the sequential multiplier.
interface alu_mult_seq_if;
   logic        start;
   logic [63:0] a;
   logic [63:0] b;
   logic        busy;
   logic        done;
   logic [63:0] product;
   logic        overflow;
   logic        zero;

   modport master (
      output start, a, b,
      input  busy, done, product, overflow, zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, product, overflow, zero
   );
endinterface

// File: rtl/alu_mult_seq.sv
// Unsigned 64x64 shift-and-add multiplier sequencing a single 64-bit ALU.
// Result is the low 64 bits of the product with an exact unsigned overflow flag.
module alu (
   input  logic [63:0] A,
   input  logic [63:0] B,
   input  logic [2:0]  cntrl,
   output logic [63:0] result,
   output logic        negative,
   output logic        zero,
   output logic        overflow,
   output logic        carry_out
);
   logic        is_sub;
   logic [63:0] bx;
   logic [64:0] sum;

   always_comb begin
      is_sub    = (cntrl == 3'b011);
      bx        = is_sub ? ~B : B;
      sum       = {1'b0, A} + {1'b0, bx} + {64'd0, is_sub};
      result    = '0;
      overflow  = 1'b0;
      carry_out = 1'b0;
      case (cntrl)
         3'b000: result = B;
         3'b010, 3'b011: begin
            result    = sum[63:0];
            carry_out = sum[64];
            overflow  = (A[63] == bx[63]) && (sum[63] != A[63]);
         end
         3'b100: result = A & B;
         3'b101: result = A | B;
         3'b110: result = A ^ B;
         default: result = '0;
      endcase
      negative = result[63];
      zero     = (result == '0);
   end
endmodule

module alu_mult_seq #(
   parameter logic [2:0]  ADD_CNTRL = 3'b010,
   parameter int unsigned ITERS     = 64
) (
   input  logic         clk,
   input  logic         reset,
   alu_mult_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [6:0] LAST = 7'(ITERS - 1);

   state_t      state_q, state_d;
   logic [63:0] product_q;
   logic [63:0] mcand;
   logic [63:0] mplier;
   logic [6:0]  count;
   logic        lost;
   logic        overflow_q;

   logic [63:0] alu_result;
   logic        alu_carry;
   logic        alu_neg_unused;
   logic        alu_zero_unused;
   logic        alu_ovf_unused;

   alu u_alu (
      .A         (product_q),
      .B         (mcand),
      .cntrl     (ADD_CNTRL),
      .result    (alu_result),
      .negative  (alu_neg_unused),
      .zero      (alu_zero_unused),
      .overflow  (alu_ovf_unused),
      .carry_out (alu_carry)
   );

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (count == LAST) state_d = DONE;
         DONE:    state_d = bus.start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Once a 1 has left the top of mcand, any later add of a set multiplier
   // bit means the true partial product no longer fits in 64 bits.
   always_ff @(posedge clk) begin
      if (!reset) begin
         product_q  <= '0;
         mcand      <= '0;
         mplier     <= '0;
         count      <= '0;
         lost       <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  mcand      <= bus.a;
                  mplier     <= bus.b;
                  product_q  <= '0;
                  overflow_q <= 1'b0;
                  lost       <= 1'b0;
                  count      <= '0;
               end
            end
            RUN: begin
               if (mplier[0]) begin
                  product_q  <= alu_result;
                  overflow_q <= overflow_q | alu_carry | lost;
               end
               mcand  <= mcand << 1;
               lost   <= lost | mcand[63];
               mplier <= mplier >> 1;
               count  <= count + 7'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
   assign bus.product  = product_q;
   assign bus.overflow = overflow_q;
   assign bus.zero     = (product_q == '0);
endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq: a 128-bit reference product feeds a scoreboard
// checked on every done pulse, along with latency, busy length and pulse width.
module tb_alu_mult_seq;
   logic clk = 1'b0;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   busy_cnt    = 0;
   logic prev_done   = 1'b0;

   typedef struct {
      logic [63:0] p;
      logic        ov;
      int          due;
   } exp_t;
   exp_t sb[$];

   alu_mult_seq_if m();

   alu_mult_seq #(.ADD_CNTRL(3'b010), .ITERS(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (m)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_op(input logic [63:0] a, input logic [63:0] b, input int due);
      logic [127:0] full;
      full = {64'd0, a} * {64'd0, b};
      sb.push_back('{full[63:0], |full[127:64], due});
   endtask

   task automatic start_op(input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      m.a     = a;
      m.b     = b;
      m.start = 1'b1;
      push_op(a, b, cyc + 65);
      @(posedge clk);
      #1 m.start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      vectors++;
      assert (sb.size() == 0) else begin
         miscompares++;
         $error("FAIL timeout observed=%0d pending expected=0 pending", sb.size());
      end
   endtask

   // Output monitor: every done pulse retires one scoreboard entry.
   always @(negedge clk) begin
      exp_t e;
      if (reset !== 1'b1) begin
         busy_cnt  = 0;
         prev_done = 1'b0;
      end else begin
         if (m.busy === 1'b1) busy_cnt++;
         if (m.done === 1'b1) begin
            chk("done_width", {63'd0, prev_done}, 64'd0);
            chk("busy_at_done", {63'd0, m.busy}, 64'd0);
            chk("busy_len", 64'(busy_cnt), 64'd64);
            busy_cnt = 0;
            vectors++;
            assert (sb.size() != 0) else begin
               miscompares++;
               $error("FAIL spurious_done observed=done expected=no done");
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("latency", 64'(cyc), 64'(e.due));
               chk("product", m.product, e.p);
               chk("overflow", {63'd0, m.overflow}, {63'd0, e.ov});
               chk("zero", {63'd0, m.zero}, {63'd0, (e.p == 64'd0)});
            end
         end
         prev_done = m.done;
      end
   end

   initial begin
      int n;
      reset   = 1'b0;
      m.start = 1'b0;
      m.a     = '0;
      m.b     = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {63'd0, m.busy}, 64'd0);
      chk("rst_done", {63'd0, m.done}, 64'd0);
      chk("rst_product", m.product, 64'd0);
      chk("rst_overflow", {63'd0, m.overflow}, 64'd0);
      chk("rst_zero", {63'd0, m.zero}, 64'd1);
      reset = 1'b1;

      // Reset mid-run: reset low at edge E+10 discards the operation.
      start_op(64'd5, 64'd7);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("midrst_busy", {63'd0, m.busy}, 64'd0);
      chk("midrst_done", {63'd0, m.done}, 64'd0);
      chk("midrst_product", m.product, 64'd0);
      chk("midrst_overflow", {63'd0, m.overflow}, 64'd0);
      reset = 1'b1;
      start_op(64'd3, 64'd4);
      wait_idle();

      start_op(64'd123456789, 64'd1000);
      wait_idle();
      start_op(64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_idle();
      start_op(64'hDEAD_BEEF, 64'd1);
      wait_idle();
      start_op(64'h8000_0000_0000_0000, 64'd2);
      wait_idle();
      start_op(64'h1_0000_0000, 64'h1_0000_0000);
      wait_idle();
      start_op(64'h8000_0000_0000_0001, 64'd1);
      wait_idle();
      start_op(64'hFFFF_FFFF, 64'hFFFF_FFFF);
      wait_idle();
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
      wait_idle();

      // A start pulse during RUN must neither queue nor alter the result.
      start_op(64'h1234_5678_9ABC, 64'h9ABC_DEF1);
      repeat (20) @(negedge clk);
      m.a     = 64'd99;
      m.b     = 64'd77;
      m.start = 1'b1;
      @(negedge clk);
      m.start = 1'b0;
      wait_idle();
      repeat (70) @(negedge clk);

      // Start held high through done: second operation accepted in the DONE cycle.
      @(negedge clk);
      m.a     = 64'd6;
      m.b     = 64'd7;
      m.start = 1'b1;
      n       = cyc;
      push_op(64'd6, 64'd7, n + 65);
      @(posedge clk);
      #1;
      m.a = '1;
      m.b = '1;
      push_op('1, '1, n + 130);
      for (int i = 0; i < 100 && m.done !== 1'b1; i++) @(negedge clk);
      @(posedge clk);
      #1 m.start = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
